rx_prbs_checker: RTL and testbench

Receive-side QPSK slicer and PRBS9 bit-error checker that sits at the output end of `channel_with_noise`. It hard-slices each noisy I/Q sample to 2 bits and self-synchronises a local PRBS9 generator to the received stream. Once locked, it counts bit errors over fixed measurement windows, which gives the BER-versus-`sigma_scale` figure for the channel model.

---
 rtl/rx_prbs_checker_if.sv | 13 +
 rtl/rx_prbs_checker.sv | 165 ++++++++++++++++
 tb/tb_rx_prbs_checker.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rx_prbs_checker_if.sv
// Receive-sample bus into rx_prbs_checker.
// Carries one noisy QPSK symbol per cycle with a valid qualifier.
// The master modport is the sample source; the slave modport is the checker.
interface rx_prbs_checker_if #(
    parameter int DWIDTH = 9
) ();
    logic signed [DWIDTH-1:0] In_I;
    logic signed [DWIDTH-1:0] In_Q;
    logic                     in_valid;

    modport master (output In_I, output In_Q, output in_valid);
    modport slave  (input  In_I, input  In_Q, input  in_valid);
endinterface

// File: rtl/rx_prbs_checker.sv
// QPSK hard slicer plus a self-synchronising PRBS9 (x^9+x^5+1) bit-error checker.
// States: SEARCH loads the local generator from received bits, VERIFY confirms
// LOCK_CNT clean predictions, and LOCKED counts bit errors per 2^WIN_LOG2-symbol
// window. Lock is dropped when a window error count exceeds LOSS_THR.
// Optional feature macro RX_CHK_TOTAL_EN builds the 32-bit saturating err_total
// counter; without it, err_total is tied to zero.
module rx_prbs_checker #(
    parameter int DWIDTH   = 9,
    parameter int WIN_LOG2 = 10,
    parameter int LOCK_CNT = 16,
    parameter int LOSS_THR = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    rx_prbs_checker_if.slave        rx,
    output logic                    locked,
    output logic [1:0]              state,
    output logic [WIN_LOG2+1:0]     err_count,
    output logic                    window_done,
    output logic [31:0]             err_total
);

    localparam int RUNW = $clog2(LOCK_CNT + 1);
    localparam int ACCW = WIN_LOG2 + 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e                state_q;
    logic                  locked_q;
    logic [8:0]            s_q;
    logic [2:0]            loadCnt_q;
    logic [RUNW-1:0]       runCnt_q;
    logic [WIN_LOG2-1:0]   winCnt_q;
    logic [ACCW-1:0]       acc_q;
    logic [ACCW-1:0]       errCount_q;
    logic                  windowDone_q;

    logic signed [DWIDTH-1:0] sampleI;
    logic signed [DWIDTH-1:0] sampleQ;
    logic                  bI;
    logic                  bQ;
    logic                  pI;
    logic                  pQ;
    logic [8:0]            sLoad_d;
    logic [8:0]            sPred_d;
    logic [1:0]            errSym_d;
    logic [ACCW-1:0]       accSum_d;
    logic [RUNW-1:0]       runNext_d;
    logic [2:0]            loadNext_d;
    logic                  winLast_d;

    // Slice the symbol, form the PRBS prediction and the per-symbol helper values.
    always_comb begin
        sampleI    = rx.In_I;
        sampleQ    = rx.In_Q;
        bI         = (sampleI < 0);
        bQ         = (sampleQ < 0);
        pI         = s_q[8] ^ s_q[4];
        pQ         = s_q[7] ^ s_q[3];
        sLoad_d    = {s_q[6:0], bI, bQ};
        sPred_d    = {s_q[6:0], pI, pQ};
        errSym_d   = {1'b0, bI ^ pI} + {1'b0, bQ ^ pQ};
        accSum_d   = acc_q + ACCW'(errSym_d);
        runNext_d  = runCnt_q + RUNW'(1);
        loadNext_d = (loadCnt_q >= 3'd4) ? 3'd5 : loadCnt_q + 3'd1;
        winLast_d  = &winCnt_q;
    end

    // Lock state machine, generator state, window accounting and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= SEARCH;
            locked_q     <= 1'b0;
            s_q          <= '0;
            loadCnt_q    <= '0;
            runCnt_q     <= '0;
            winCnt_q     <= '0;
            acc_q        <= '0;
            errCount_q   <= '0;
            windowDone_q <= 1'b0;
        end else begin
            windowDone_q <= 1'b0;
            if (rx.in_valid) begin
                unique case (state_q)
                    SEARCH: begin
                        s_q       <= sLoad_d;
                        loadCnt_q <= loadNext_d;
                        if (loadNext_d == 3'd5 && sLoad_d != 9'd0) begin
                            state_q  <= VERIFY;
                            runCnt_q <= '0;
                        end
                    end
                    VERIFY: begin
                        if ({bI, bQ} == {pI, pQ}) begin
                            s_q <= sPred_d;
                            if (runNext_d == RUNW'(LOCK_CNT)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                                runCnt_q <= '0;
                                winCnt_q <= '0;
                                acc_q    <= '0;
                            end else begin
                                runCnt_q <= runNext_d;
                            end
                        end else begin
                            state_q   <= SEARCH;
                            loadCnt_q <= '0;
                            runCnt_q  <= '0;
                        end
                    end
                    LOCKED: begin
                        s_q      <= sPred_d;
                        winCnt_q <= winCnt_q + WIN_LOG2'(1);
                        if (winLast_d) begin
                            errCount_q   <= accSum_d;
                            windowDone_q <= 1'b1;
                            acc_q        <= '0;
                            if (accSum_d > ACCW'(LOSS_THR)) begin
                                state_q   <= SEARCH;
                                locked_q  <= 1'b0;
                                loadCnt_q <= '0;
                            end
                        end else begin
                            acc_q <= accSum_d;
                        end
                    end
                    default: begin
                        state_q  <= SEARCH;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RX_CHK_TOTAL_EN
    logic [31:0] errTotal_q;
    logic [32:0] totalSum_d;

    assign totalSum_d = {1'b0, errTotal_q} + 33'(errSym_d);

    // Saturating running total of every bit error seen while locked.
    always_ff @(posedge clk) begin
        if (!rst) begin
            errTotal_q <= '0;
        end else if (rx.in_valid && state_q == LOCKED) begin
            errTotal_q <= totalSum_d[32] ? 32'hFFFF_FFFF : totalSum_d[31:0];
        end
    end

    assign err_total = errTotal_q;
`else
    assign err_total = '0;
`endif

    assign state       = state_q;
    assign locked      = locked_q;
    assign err_count   = errCount_q;
    assign window_done = windowDone_q;

endmodule

// File: tb/tb_rx_prbs_checker.sv
// Directed testbench for rx_prbs_checker: clean lock, error injection,
// valid gaps, loss of lock, reset while locked, VERIFY failure and zero input.
// Expected err_total depends on whether RX_CHK_TOTAL_EN is defined.
module tb_rx_prbs_checker;

    localparam int DW   = 9;
    localparam int WL2  = 10;
    localparam int WIN  = 1 << WL2;

`ifdef RX_CHK_TOTAL_EN
    localparam bit TOTAL_EN = 1'b1;
`else
    localparam bit TOTAL_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              locked;
    logic [1:0]        state;
    logic [WL2+1:0]    err_count;
    logic              window_done;
    logic [31:0]       err_total;

    rx_prbs_checker_if #(.DWIDTH(DW)) bus ();

    rx_prbs_checker #(
        .DWIDTH   (DW),
        .WIN_LOG2 (WL2),
        .LOCK_CNT (16),
        .LOSS_THR (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (bus),
        .locked      (locked),
        .state       (state),
        .err_count   (err_count),
        .window_done (window_done),
        .err_total   (err_total)
    );

    int         totalChecks = 0;
    int         badChecks   = 0;
    int         doneSeen    = 0;
    logic [8:0] genState;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every window_done pulse, sampled away from the rising edge.
    always @(negedge clk) begin
        if (window_done) doneSeen++;
    end

    // Compare one observed value with its expected value and log a mismatch.
    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        totalChecks++;
        if (observed != expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Drive raw samples for one cycle, then settle just after the edge.
    task automatic applyRaw(input logic signed [DW-1:0] i, input logic signed [DW-1:0] q,
                            input logic valid);
        bus.In_I     = i;
        bus.In_Q     = q;
        bus.in_valid = valid;
        @(posedge clk);
        #1;
    endtask

    // Drive one symbol from bits (1 maps to -100, 0 maps to +100).
    task automatic applyStimulus(input logic bitI, input logic bitQ, input logic valid);
        applyRaw(bitI ? -9'sd100 : 9'sd100, bitQ ? -9'sd100 : 9'sd100, valid);
    endtask

    // Advance the reference PRBS9 one symbol, returning its two bits.
    task automatic nextPrbs(output logic pI, output logic pQ);
        pI       = genState[8] ^ genState[4];
        pQ       = genState[7] ^ genState[3];
        genState = {genState[6:0], pI, pQ};
    endtask

    // Send the next PRBS symbol, optionally inverting I and/or Q.
    task automatic sendPrbs(input logic flipI, input logic flipQ);
        logic pI, pQ;
        nextPrbs(pI, pQ);
        applyStimulus(pI ^ flipI, pQ ^ flipQ, 1'b1);
    endtask

    // Send a random symbol in place of the next PRBS symbol; report its bit errors.
    task automatic sendRandom(output int errs);
        logic pI, pQ, rI, rQ;
        nextPrbs(pI, pQ);
        rI   = 1'($urandom_range(0, 1));
        rQ   = 1'($urandom_range(0, 1));
        errs = int'(rI ^ pI) + int'(rQ ^ pQ);
        applyStimulus(rI, rQ, 1'b1);
    endtask

    initial begin
        int     startDone;
        int     randErrs;
        int     e;
        longint expTotal;
        bit     leftSearch;

        rst          = 1'b0;
        bus.In_I     = '0;
        bus.In_Q     = '0;
        bus.in_valid = 1'b0;
        genState     = 9'h1FF;
        expTotal     = 0;

        // Power-on reset values.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("rst_state", state, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_err_count", err_count, 0);
        checkOutput("rst_window_done", window_done, 0);
        checkOutput("rst_err_total", err_total, 0);
        rst = 1'b1;

        // Clean lock: VERIFY after 5 symbols, LOCKED on the 21st.
        repeat (5) sendPrbs(1'b0, 1'b0);
        checkOutput("verify_after_5", state, 1);
        repeat (15) sendPrbs(1'b0, 1'b0);
        checkOutput("not_locked_20", locked, 0);
        sendPrbs(1'b0, 1'b0);
        checkOutput("locked_21", locked, 1);
        checkOutput("state_locked_21", state, 2);

        // First window: 1024 clean symbols, pulse only on the last.
        startDone = doneSeen;
        repeat (WIN - 1) sendPrbs(1'b0, 1'b0);
        checkOutput("no_early_done", doneSeen - startDone, 0);
        sendPrbs(1'b0, 1'b0);
        checkOutput("win1_done", window_done, 1);
        checkOutput("win1_err_count", err_count, 0);
        checkOutput("win1_err_total", err_total, 0);

        // Error injection: 3 single-I flips and one I+Q flip.
        for (int i = 0; i < WIN; i++) begin
            if (i == 10 || i == 20 || i == 30) sendPrbs(1'b1, 1'b0);
            else if (i == 40)                  sendPrbs(1'b1, 1'b1);
            else                               sendPrbs(1'b0, 1'b0);
        end
        expTotal = TOTAL_EN ? 5 : 0;
        checkOutput("win2_done", window_done, 1);
        checkOutput("win2_err_count", err_count, 5);
        checkOutput("win2_err_total", err_total, expTotal);
        checkOutput("win2_still_locked", locked, 1);

        // Window measured in symbols while in_valid toggles every other cycle.
        startDone = doneSeen;
        for (int i = 0; i < WIN; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (i == 0) checkOutput("done_one_cycle", window_done, 0);
            sendPrbs(1'b0, 1'b0);
        end
        checkOutput("gap_no_early_done", doneSeen - startDone, 1);
        checkOutput("gap_win_done", window_done, 1);
        checkOutput("gap_err_count", err_count, 0);
        checkOutput("gap_state", state, 2);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("gap_done_falls", window_done, 0);
        checkOutput("gap_err_total", err_total, expTotal);

        // Loss of lock: a full window of random bits.
        randErrs = 0;
        for (int i = 0; i < WIN; i++) begin
            sendRandom(e);
            randErrs += e;
        end
        if (TOTAL_EN) expTotal += randErrs;
        checkOutput("loss_done", window_done, 1);
        checkOutput("loss_locked", locked, 0);
        checkOutput("loss_state", state, 0);
        checkOutput("loss_err_count", err_count, randErrs);
        checkOutput("loss_over_thr", (err_count > 64) ? 1 : 0, 1);
        checkOutput("loss_err_total", err_total, expTotal);

        // Relock within 21 symbols of clean PRBS; err_count holds meanwhile.
        repeat (20) sendPrbs(1'b0, 1'b0);
        checkOutput("relock_not_yet", locked, 0);
        checkOutput("err_count_held", err_count, randErrs);
        sendPrbs(1'b0, 1'b0);
        checkOutput("relock_21", locked, 1);

        // Reset for 4 cycles in the middle of a locked window.
        repeat (100) sendPrbs(1'b0, 1'b0);
        startDone = doneSeen;
        rst = 1'b0;
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("midrst_state", state, 0);
        checkOutput("midrst_locked", locked, 0);
        checkOutput("midrst_err_count", err_count, 0);
        checkOutput("midrst_err_total", err_total, 0);
        checkOutput("midrst_window_done", window_done, 0);
        rst = 1'b1;

        // VERIFY failure: corrupt the 3rd symbol after SEARCH completes.
        repeat (5) sendPrbs(1'b0, 1'b0);
        checkOutput("vf_verify", state, 1);
        repeat (2) sendPrbs(1'b0, 1'b0);
        sendPrbs(1'b1, 1'b0);
        checkOutput("vf_back_to_search", state, 0);
        repeat (20) sendPrbs(1'b0, 1'b0);
        checkOutput("vf_not_locked_20", locked, 0);
        sendPrbs(1'b0, 1'b0);
        checkOutput("vf_locked_21", locked, 1);
        checkOutput("vf_no_done_since_rst", doneSeen - startDone, 0);

        // All-zero input never leaves SEARCH.
        rst = 1'b0;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        leftSearch = 1'b0;
        for (int i = 0; i < 200; i++) begin
            applyRaw('0, '0, 1'b1);
            if (state != 2'd0) leftSearch = 1'b1;
        end
        checkOutput("zero_left_search", leftSearch, 0);
        checkOutput("zero_locked", locked, 0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
